// File: rtl/adc_meter_pkg.sv
// Shared constants and the crossing-detector state encoding for the ADC frequency meter.
package adc_meter_pkg;

    localparam int          MID_CODE = 128;
    localparam logic [19:0] DISP_MAX = 20'd999999;

    typedef enum logic [1:0] {
        ZC_UNKNOWN = 2'b00,
        ZC_LOW     = 2'b01,
        ZC_HIGH    = 2'b10
    } zc_state_t;

    // Increment that sticks at the largest value the display can show.
    function automatic logic [19:0] sat_inc(input logic [19:0] value);
        return (value >= DISP_MAX) ? DISP_MAX : value + 20'd1;
    endfunction

endpackage

// File: rtl/zero_cross_detect.sv
// Hysteresis crossing detector around mid-code; emits a one-cycle rise pulse on LOW->HIGH.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ZC_UNKNOWN | no sample outside the hysteresis band seen yet since reset
//   ZC_LOW     | last out-of-band sample was at or below MID_CODE-HYST
//   ZC_HIGH    | last out-of-band sample was at or above MID_CODE+HYST
module zero_cross_detect
    import adc_meter_pkg::*;
#(
    parameter int HYST = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] adc_data,
    input  logic       adc_valid,
    output logic       rise
);

    localparam logic [8:0] HIGH_TH = 9'(MID_CODE + HYST);
    localparam logic [8:0] LOW_TH  = 9'(MID_CODE - HYST);

    zc_state_t  state;
    logic       above;
    logic       below;

    assign above = ({1'b0, adc_data} >= HIGH_TH);
    assign below = ({1'b0, adc_data} <= LOW_TH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ZC_UNKNOWN;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (adc_valid) begin
                case (state)
                    ZC_UNKNOWN: begin
                        // Entering HIGH from UNKNOWN is not a rising crossing.
                        if (above)
                            state <= ZC_HIGH;
                        else if (below)
                            state <= ZC_LOW;
                    end
                    ZC_LOW: begin
                        if (above) begin
                            state <= ZC_HIGH;
                            rise  <= 1'b1;
                        end
                    end
                    ZC_HIGH: begin
                        if (below)
                            state <= ZC_LOW;
                    end
                    default: state <= ZC_UNKNOWN;
                endcase
            end
        end
    end

endmodule

// File: rtl/adc_freq_meter.sv
// Gated frequency (and optional amplitude) meter for an ADC stream.
// Amplitude tracking and the KEY_STATE[4] display toggle exist only with ADC_FREQ_METER_AMP_EN.
module adc_freq_meter
    import adc_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50000000,
    parameter int HYST        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  adc_data,
    input  logic        adc_valid,
    input  logic [9:0]  KEY_STATE,
    output logic [19:0] number_on_digitron,
    output logic [5:0]  point_position,
    output logic        freq_update
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    logic [GW-1:0] gate_cnt;
    logic          gate_last;
    logic          rise;
    logic [19:0]   edge_count;
    logic [19:0]   freq_reg;
    logic [19:0]   disp_src;
    logic          unused_key;

    zero_cross_detect #(
        .HYST      (HYST)
    ) u_zero_cross_detect (
        .clk       (clk),
        .rst       (rst),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .rise      (rise)
    );

    assign gate_last = (gate_cnt == GW'(GATE_CYCLES - 1));

    // A crossing on the last gate cycle belongs to the closing gate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt    <= '0;
            edge_count  <= '0;
            freq_reg    <= '0;
            freq_update <= 1'b0;
        end else begin
            freq_update <= gate_last;
            if (gate_last) begin
                gate_cnt   <= '0;
                freq_reg   <= rise ? sat_inc(edge_count) : edge_count;
                edge_count <= '0;
            end else begin
                gate_cnt <= gate_cnt + GW'(1);
                if (rise)
                    edge_count <= sat_inc(edge_count);
            end
        end
    end

`ifdef ADC_FREQ_METER_AMP_EN
    logic [7:0]  min_q;
    logic [7:0]  max_q;
    logic [7:0]  min_n;
    logic [7:0]  max_n;
    logic [19:0] amp_reg;
    logic        show_flag;
    logic        key_used;

    always_comb begin
        min_n = min_q;
        max_n = max_q;
        if (adc_valid) begin
            if (adc_data < min_q)
                min_n = adc_data;
            if (adc_data > max_q)
                max_n = adc_data;
        end
    end

    // An empty gate leaves min=255/max=0, which the max>=min test turns into 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q   <= 8'd255;
            max_q   <= 8'd0;
            amp_reg <= '0;
        end else if (gate_last) begin
            amp_reg <= (max_n >= min_n) ? {12'd0, 8'(max_n - min_n)} : 20'd0;
            min_q   <= 8'd255;
            max_q   <= 8'd0;
        end else begin
            min_q <= min_n;
            max_q <= max_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            show_flag <= 1'b1;
            key_used  <= 1'b0;
        end else begin
            key_used <= KEY_STATE[4];
            if (KEY_STATE[4] && !key_used)
                show_flag <= ~show_flag;
        end
    end

    assign disp_src   = show_flag ? freq_reg : amp_reg;
    assign unused_key = ^{KEY_STATE[9:5], KEY_STATE[3:0]};
`else
    assign disp_src   = freq_reg;
    assign unused_key = ^KEY_STATE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            number_on_digitron <= '0;
            point_position     <= '0;
        end else begin
            number_on_digitron <= disp_src;
            point_position     <= 6'b000000;
        end
    end

endmodule

// File: tb/tb_adc_freq_meter.sv
// Directed bench for adc_freq_meter with a 1000-cycle gate and HYST=8.
module tb_adc_freq_meter;

    localparam int GATE = 1000;

`ifdef ADC_FREQ_METER_AMP_EN
    localparam bit AMP_EN = 1'b1;
`else
    localparam bit AMP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  adc_data = 8'd0;
    logic        adc_valid = 1'b0;
    logic [9:0]  KEY_STATE = 10'd0;
    logic [19:0] number_on_digitron;
    logic [5:0]  point_position;
    logic        freq_update;

    int n_cmp = 0;
    int n_err = 0;
    int gk = 0;
    int upd_cnt = 0;

    always #5 clk = ~clk;

    adc_freq_meter #(
        .GATE_CYCLES        (GATE),
        .HYST               (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .adc_data           (adc_data),
        .adc_valid          (adc_valid),
        .KEY_STATE          (KEY_STATE),
        .number_on_digitron (number_on_digitron),
        .point_position     (point_position),
        .freq_update        (freq_update)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sq(input int k);
        return ((k % 10) < 5) ? 8'd0 : 8'd255;
    endfunction

    // Returns {valid, data} for posedge index k of the given stimulus mode.
    function automatic logic [8:0] pattern(input int mode, input int k);
        case (mode)
            0: return {1'b1, sq(k)};
            1: return {(k < GATE), (k < 50) ? sq(k) : 8'd0};
            2: begin
                if (k == 1100) return {1'b1, 8'd100};
                if (k == 1500) return {1'b1, 8'd137};
                return {1'b1, (k % 2 == 1) ? 8'd132 : 8'd124};
            end
            3: return {1'b1, 8'd200};
            4: begin
                if (k == 0 || k == 1000) return {1'b1, 8'd0};
                if (k == 998 || k == 1999) return {1'b1, 8'd255};
                return 9'd0;
            end
            6: return {1'b1, (k < 30) ? sq(k) : 8'd0};
            default: return 9'd0;
        endcase
    endfunction

    task automatic tick(input logic [7:0] d, input logic v);
        adc_data  = d;
        adc_valid = v;
        @(posedge clk);
        #1;
        if (freq_update) upd_cnt++;
        gk++;
    endtask

    // Consumes posedges gk..stop-1 using the given mode.
    task automatic run_until(input int mode, input int stop);
        logic [8:0] p;
        while (gk < stop) begin
            p = pattern(mode, gk);
            tick(p[7:0], p[8]);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        adc_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        gk      = 0;
        upd_cnt = 0;
    endtask

    initial begin
        // Square wave 0/255, period 10 -> 100 rising crossings per gate.
        do_reset();
        check("rst_disp", number_on_digitron, 0);
        check("rst_point", point_position, 0);
        check("rst_update", freq_update, 0);
        run_until(0, 500);
        check("partial_hidden", number_on_digitron, 0);
        run_until(0, 999);
        check("update_early", freq_update, 0);
        run_until(0, 1000);
        check("update_pulse", freq_update, 1);
        run_until(0, 1001);
        check("update_one_cycle", freq_update, 0);
        check("square_gate0", number_on_digitron, 100);
        check("square_point", point_position, 0);
        run_until(0, 2001);
        check("square_gate1", number_on_digitron, 100);
        check("update_count", upd_cnt, 2);

        // 37 crossings into gate 2, then reset discards them.
        run_until(0, 2370);
        rst = 1'b1;
        #1;
        check("midrst_disp", number_on_digitron, 0);
        check("midrst_point", point_position, 0);
        check("midrst_update", freq_update, 0);
        do_reset();
        run_until(1, 1001);
        check("post_rst_count", number_on_digitron, 5);

        // Held key toggles once; amplitude of last gate is 255.
        KEY_STATE = 10'b00_0001_0000;
        run_until(5, 1051);
        check("key_held", number_on_digitron, AMP_EN ? 255 : 5);
        KEY_STATE = 10'd0;
        run_until(5, 1060);
        check("key_release", number_on_digitron, AMP_EN ? 255 : 5);
        run_until(5, 2001);
        check("no_valid_gate", number_on_digitron, 0);

        // Reset must bring the display back to frequency.
        do_reset();
        run_until(6, 1001);
        check("rst_show_freq", number_on_digitron, 3);

        // Inside the hysteresis band nothing counts; a glitch to 137 from LOW counts once.
        do_reset();
        run_until(2, 1001);
        check("hyst_band", number_on_digitron, 0);
        run_until(2, 2001);
        check("hyst_glitch", number_on_digitron, 1);

        // UNKNOWN->HIGH is not a crossing.
        do_reset();
        run_until(3, 1001);
        check("unknown_high", number_on_digitron, 0);

        // Crossing pulse on cycle 999 closes into gate 0; on cycle 0 opens gate 2.
        do_reset();
        run_until(4, 1001);
        check("cross_cycle999", number_on_digitron, 1);
        run_until(4, 2001);
        check("next_gate_zero", number_on_digitron, 0);
        run_until(4, 3001);
        check("cross_cycle0", number_on_digitron, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
